// File: rtl/axi_ad9684_delay_cal_pkg.sv
// Shared definitions for the AD9684 IDELAY calibration sequencer:
// FSM state encoding, default widths and tap-range helper.
package ad9684_cal_pkg;

   localparam int DEF_DATA_WIDTH = 15;
   localparam int DEF_TAP_WIDTH  = 5;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_LK,
      S_LOAD,
      S_SETTLE,
      S_CHECK,
      S_NEXT,
      S_APPLY,
      S_FLOAD,
      S_DONE,
      S_FAIL
   } cal_state_t;

   // highest tap reachable with a given tap field width
   function automatic int tap_max(input int tap_width);
      return (1 << tap_width) - 1;
   endfunction

endpackage

// File: rtl/axi_ad9684_delay_cal_if.sv
// Delay-load bus between the calibration sequencer and up_delay_cntrl.
// up_dld: per-lane load strobe; up_dwdata: per-lane tap value.
interface axi_ad9684_delay_cal_if #(
   parameter int DATA_WIDTH = 15,
   parameter int TAP_WIDTH  = 5
);
   logic [DATA_WIDTH-1:0]           up_dld;
   logic [DATA_WIDTH*TAP_WIDTH-1:0] up_dwdata;

   modport master (output up_dld, output up_dwdata);
   modport slave  (input  up_dld, input  up_dwdata);
endinterface

// File: rtl/axi_ad9684_cal_window.sv
// Longest passing tap window tracker (no wrap-around).
// Ports: clear/step/pass/last/tap in; best_start/best_len out.
module axi_ad9684_cal_window #(
   parameter int TAP_WIDTH = 5
) (
   input  logic                 up_clk,
   input  logic                 up_rstn,
   input  logic                 clear,
   input  logic                 step,
   input  logic                 pass,
   input  logic                 last,
   input  logic [TAP_WIDTH-1:0] tap,
   output logic [TAP_WIDTH-1:0] best_start,
   output logic [TAP_WIDTH:0]   best_len
);

   logic [TAP_WIDTH-1:0] cur_start;
   logic [TAP_WIDTH-1:0] start_n;
   logic [TAP_WIDTH:0]   cur_len;
   logic [TAP_WIDTH:0]   len_inc;

   // a new window starts at the first pass after a fail
   assign start_n = (cur_len == '0) ? tap : cur_start;
   assign len_inc = cur_len + 1'b1;

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         cur_start  <= '0;
         cur_len    <= '0;
         best_start <= '0;
         best_len   <= '0;
      end else if (clear) begin
         cur_start  <= '0;
         cur_len    <= '0;
         best_start <= '0;
         best_len   <= '0;
      end else if (step) begin
         if (pass && !last) begin
            cur_start <= start_n;
            cur_len   <= len_inc;
         end else if (pass) begin
            // strict compare: ties keep the lower window
            if (len_inc > best_len) begin
               best_start <= start_n;
               best_len   <= len_inc;
            end
            cur_len <= '0;
         end else begin
            if (cur_len > best_len) begin
               best_start <= cur_start;
               best_len   <= cur_len;
            end
            cur_len <= '0;
         end
      end
   end

endmodule

// File: rtl/axi_ad9684_delay_cal.sv
// AD9684 IDELAY calibration: sweeps one common tap, qualifies PN status,
// loads the centre of the longest passing window. Ports: cal_* control and
// status, delay_locked, up_pn_err/oos, delay-load bus (dly).
module axi_ad9684_delay_cal
   import ad9684_cal_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int TAP_WIDTH     = DEF_TAP_WIDTH,
   parameter int SETTLE_CYCLES = 64,
   parameter int DWELL_CYCLES  = 1024,
   parameter int MIN_WINDOW    = 4,
   parameter int FAIL_TAP      = 16
) (
   input  logic                 up_clk,
   input  logic                 up_rstn,
   input  logic                 cal_start,
   output logic                 cal_busy,
   output logic                 cal_done,
   output logic                 cal_fail,
   output logic [TAP_WIDTH-1:0] cal_tap,
   output logic [TAP_WIDTH:0]   cal_win_len,
   input  logic                 delay_locked,
   input  logic                 up_pn_err,
   input  logic                 up_pn_oos,
   axi_ad9684_delay_cal_if.master dly
);

   localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ?
                            SETTLE_CYCLES : DWELL_CYCLES;
   localparam int CW = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_CYCLES - 1);
   localparam logic [TAP_WIDTH-1:0] TAP_MAX = TAP_WIDTH'(tap_max(TAP_WIDTH));
   localparam logic [TAP_WIDTH-1:0] FAIL_T  = TAP_WIDTH'(FAIL_TAP);

   cal_state_t           state, state_n;
   logic                 lock_m, lock_s;
   logic [TAP_WIDTH-1:0] tap;
   logic [CW-1:0]        cnt;
   logic                 err_q, pass_q, ok_q;
   logic [TAP_WIDTH:0]   win_q;
   logic                 dld_en, win_clr, win_step;
   logic                 abort, last, pn_bad;
   logic [TAP_WIDTH-1:0] best_start;
   logic [TAP_WIDTH:0]   best_len;
   logic [TAP_WIDTH:0]   centre;

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= delay_locked;
         lock_s <= lock_m;
      end
   end

   assign pn_bad = up_pn_err | up_pn_oos;
   assign last   = (tap == TAP_MAX);
   assign centre = {1'b0, best_start} + (best_len >> 1);
   // losing lock once the sweep has started invalidates every result
   assign abort  = ~lock_s &
                   (state inside {S_LOAD, S_SETTLE, S_CHECK, S_NEXT, S_APPLY});

   assign dly.up_dld    = {DATA_WIDTH{dld_en}};
   assign dly.up_dwdata = {DATA_WIDTH{tap}};

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) state <= S_IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n  = state;
      dld_en   = 1'b0;
      win_clr  = 1'b0;
      win_step = 1'b0;
      unique case (state)
         S_IDLE:    if (cal_start) begin
                       state_n = S_WAIT_LK;
                       win_clr = 1'b1;
                    end
         S_WAIT_LK: if (lock_s) state_n = S_LOAD;
         S_LOAD:    begin
                       dld_en  = 1'b1;
                       state_n = S_SETTLE;
                    end
         S_SETTLE:  if (cnt == SETTLE_LAST) state_n = S_CHECK;
         S_CHECK:   if (cnt == DWELL_LAST) state_n = S_NEXT;
         S_NEXT:    begin
                       win_step = 1'b1;
                       state_n  = last ? S_APPLY : S_LOAD;
                    end
         S_APPLY:   state_n = S_FLOAD;
         S_FLOAD:   begin
                       dld_en  = 1'b1;
                       state_n = ok_q ? S_DONE : S_FAIL;
                    end
         S_DONE:    state_n = S_IDLE;
         S_FAIL:    state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
      if (abort) begin
         state_n = S_FLOAD;
         dld_en  = 1'b0;
      end
   end

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         tap         <= '0;
         cnt         <= '0;
         err_q       <= 1'b0;
         pass_q      <= 1'b0;
         ok_q        <= 1'b0;
         win_q       <= '0;
         cal_busy    <= 1'b0;
         cal_done    <= 1'b0;
         cal_fail    <= 1'b0;
         cal_tap     <= '0;
         cal_win_len <= '0;
      end else if (abort) begin
         tap   <= FAIL_T;
         ok_q  <= 1'b0;
         win_q <= '0;
         cnt   <= '0;
      end else begin
         unique case (state)
            S_IDLE: if (cal_start) begin
                       tap      <= '0;
                       cal_busy <= 1'b1;
                       cal_done <= 1'b0;
                       cal_fail <= 1'b0;
                    end
            S_LOAD: begin
                       cnt   <= '0;
                       err_q <= 1'b0;
                    end
            S_SETTLE: cnt <= (cnt == SETTLE_LAST) ? '0 : cnt + 1'b1;
            S_CHECK: if (cnt == DWELL_LAST) begin
                        cnt    <= '0;
                        pass_q <= ~(err_q | pn_bad);
                     end else begin
                        cnt   <= cnt + 1'b1;
                        err_q <= err_q | pn_bad;
                     end
            S_NEXT: if (!last) tap <= tap + 1'b1;
            S_APPLY: begin
                        win_q <= best_len;
                        if (int'(best_len) >= MIN_WINDOW) begin
                           tap  <= TAP_WIDTH'(centre);
                           ok_q <= 1'b1;
                        end else begin
                           tap  <= FAIL_T;
                           ok_q <= 1'b0;
                        end
                     end
            S_DONE: begin
                       cal_done    <= 1'b1;
                       cal_busy    <= 1'b0;
                       cal_tap     <= tap;
                       cal_win_len <= win_q;
                    end
            S_FAIL: begin
                       cal_fail    <= 1'b1;
                       cal_busy    <= 1'b0;
                       cal_tap     <= tap;
                       cal_win_len <= win_q;
                    end
            default: ;
         endcase
      end
   end

   axi_ad9684_cal_window #(
      .TAP_WIDTH (TAP_WIDTH)
   ) i_window (
      .up_clk     (up_clk),
      .up_rstn    (up_rstn),
      .clear      (win_clr),
      .step       (win_step),
      .pass       (pass_q),
      .last       (last),
      .tap        (tap),
      .best_start (best_start),
      .best_len   (best_len)
   );

endmodule

// File: tb/tb_axi_ad9684_delay_cal.sv
// Bench for axi_ad9684_delay_cal: table of pass-mask sweeps plus
// glitch, lock-loss, reset and busy-restart sequences.
module tb_axi_ad9684_delay_cal;

   typedef struct {
      string       name;
      logic [31:0] mask;
      bit          exp_done;
      int          exp_tap;
      int          exp_win;
      int          exp_pulses;
   } vec_t;

   logic        up_clk;
   logic        up_rstn;
   logic        cal_start;
   logic        cal_busy;
   logic        cal_done;
   logic        cal_fail;
   logic [4:0]  cal_tap;
   logic [5:0]  cal_win_len;
   logic        delay_locked;
   logic        up_pn_err;
   logic        up_pn_oos;
   logic [31:0] pass_mask;
   logic [4:0]  cur_tap;

   int tests;
   int fails;
   int pulse_cnt;
   int bus_bad;
   int last_ld_tap;
   int base_pulses;
   int base_bad;

   vec_t vecs[5];

   axi_ad9684_delay_cal_if #(.DATA_WIDTH(15), .TAP_WIDTH(5)) dly_if ();

   axi_ad9684_delay_cal #(
      .DATA_WIDTH    (15),
      .TAP_WIDTH     (5),
      .SETTLE_CYCLES (4),
      .DWELL_CYCLES  (8),
      .MIN_WINDOW    (4),
      .FAIL_TAP      (16)
   ) dut (
      .up_clk       (up_clk),
      .up_rstn      (up_rstn),
      .cal_start    (cal_start),
      .cal_busy     (cal_busy),
      .cal_done     (cal_done),
      .cal_fail     (cal_fail),
      .cal_tap      (cal_tap),
      .cal_win_len  (cal_win_len),
      .delay_locked (delay_locked),
      .up_pn_err    (up_pn_err),
      .up_pn_oos    (up_pn_oos),
      .dly          (dly_if)
   );

   initial up_clk = 1'b0;
   always #5 up_clk = ~up_clk;

   // the "link" passes only at taps whose mask bit is set
   assign cur_tap   = dly_if.up_dwdata[4:0];
   assign up_pn_oos = ~pass_mask[cur_tap];

   always @(negedge up_clk) begin
      if (dly_if.up_dld != '0) begin
         pulse_cnt   = pulse_cnt + 1;
         last_ld_tap = int'(cur_tap);
         if (dly_if.up_dld != 15'h7fff ||
             dly_if.up_dwdata != {15{cur_tap}})
            bus_bad = bus_bad + 1;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests = tests + 1;
      if (act != exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic kick();
      base_pulses = pulse_cnt;
      base_bad    = bus_bad;
      @(posedge up_clk); #1 cal_start = 1'b1;
      @(posedge up_clk); #1 cal_start = 1'b0;
   endtask

   task automatic wait_load(input int t);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 1000 && !hit; i++) begin
         @(negedge up_clk);
         if (dly_if.up_dld != '0 && int'(cur_tap) == t) hit = 1'b1;
      end
      chk($sformatf("load_seen_tap%0d", t), int'(hit), 1);
   endtask

   task automatic finish_check(input string nm, input bit done,
                               input int tap, input int win,
                               input int pulses);
      for (int i = 0; i < 3000 && cal_busy; i++) begin
         @(posedge up_clk); #1;
      end
      chk({nm, ".busy"}, int'(cal_busy), 0);
      chk({nm, ".done"}, int'(cal_done), int'(done));
      chk({nm, ".fail"}, int'(cal_fail), int'(!done));
      chk({nm, ".tap"}, int'(cal_tap), tap);
      chk({nm, ".win"}, int'(cal_win_len), win);
      chk({nm, ".pulses"}, pulse_cnt - base_pulses, pulses);
      chk({nm, ".last_load"}, last_ld_tap, tap);
      chk({nm, ".bus"}, bus_bad - base_bad, 0);
      chk({nm, ".excl"}, int'(cal_done & cal_fail), 0);
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      pulse_cnt    = 0;
      bus_bad      = 0;
      last_ld_tap  = -1;
      up_rstn      = 1'b0;
      cal_start    = 1'b0;
      delay_locked = 1'b1;
      up_pn_err    = 1'b0;
      pass_mask    = '1;

      vecs[0] = '{"win8_20",   32'h001f_ff00, 1'b1, 14, 13, 33};
      vecs[1] = '{"two_win",   32'hffc0_003c, 1'b1, 27, 10, 33};
      vecs[2] = '{"tie",       32'h0000_fc3f, 1'b1,  3,  6, 33};
      vecs[3] = '{"all_fail",  32'h0000_0000, 1'b0, 16,  0, 33};
      vecs[4] = '{"all_pass",  32'hffff_ffff, 1'b1, 16, 32, 33};

      repeat (3) @(posedge up_clk);
      #1;
      chk("rst.busy", int'(cal_busy), 0);
      chk("rst.done", int'(cal_done), 0);
      chk("rst.fail", int'(cal_fail), 0);
      chk("rst.tap", int'(cal_tap), 0);
      chk("rst.win", int'(cal_win_len), 0);
      chk("rst.dld", int'(dly_if.up_dld), 0);
      chk("rst.dwdata", int'(dly_if.up_dwdata == '0), 1);
      @(posedge up_clk); #1 up_rstn = 1'b1;
      repeat (2) @(posedge up_clk);

      for (int v = 0; v < 5; v++) begin
         pass_mask = vecs[v].mask;
         kick();
         finish_check(vecs[v].name, vecs[v].exp_done, vecs[v].exp_tap,
                      vecs[v].exp_win, vecs[v].exp_pulses);
      end

      // one-cycle error inside tap 12 dwell splits the window
      pass_mask = '1;
      kick();
      wait_load(12);
      repeat (8) @(posedge up_clk);
      #1 up_pn_err = 1'b1;
      @(posedge up_clk); #1 up_pn_err = 1'b0;
      finish_check("glitch", 1'b1, 22, 19, 33);

      // lock lost while settling at tap 10
      kick();
      wait_load(10);
      repeat (2) @(posedge up_clk);
      #1 delay_locked = 1'b0;
      finish_check("lock_loss", 1'b0, 16, 0, 12);
      delay_locked = 1'b1;
      repeat (4) @(posedge up_clk);

      // reset mid-dwell, then a clean run
      kick();
      wait_load(5);
      repeat (7) @(posedge up_clk);
      #1 up_rstn = 1'b0;
      @(negedge up_clk);
      chk("rst2.busy", int'(cal_busy), 0);
      chk("rst2.fail", int'(cal_fail), 0);
      chk("rst2.tap", int'(cal_tap), 0);
      chk("rst2.dwdata", int'(dly_if.up_dwdata == '0), 1);
      @(posedge up_clk); #1 up_rstn = 1'b1;
      kick();
      finish_check("after_rst", 1'b1, 16, 32, 33);

      // start pulse while busy must not restart the sweep
      pass_mask = 32'h001f_ff00;
      kick();
      wait_load(3);
      @(posedge up_clk); #1 cal_start = 1'b1;
      @(posedge up_clk); #1 cal_start = 1'b0;
      chk("busy_start.busy", int'(cal_busy), 1);
      finish_check("busy_start", 1'b1, 14, 13, 33);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
